// File: rtl/commit_monitor.sv
// commit_monitor: multi-channel retire monitor. Assigns RVFI order numbers
// to up to NRET retiring instructions per cycle in channel order, detects a
// program halt (control transfer to itself repeated HALT_REPEAT times) and
// an idle-cycle stall timeout.
// Optional feature: define COMMIT_MONITOR_PC_CHECK_EN to track the expected
// PC and flag discontinuities on pc_error; otherwise pc_error is tied low.
module commit_monitor #(
   parameter int NRET        = 1,
   parameter int XLEN        = 32,
   parameter int ORDER_W     = 64,
   parameter int TIMEOUT_W   = 32,
   parameter int HALT_REPEAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NRET-1:0]         commit_valid,
   input  logic [NRET*XLEN-1:0]    commit_pc,
   input  logic [NRET*XLEN-1:0]    commit_next_pc,
   input  logic [NRET-1:0]         commit_is_ctrl,
   input  logic [TIMEOUT_W-1:0]    timeout_limit,
   output logic [NRET*ORDER_W-1:0] order_out,
   output logic [NRET-1:0]         commit_accept,
   output logic [ORDER_W-1:0]      order_next,
   output logic                    halt,
   output logic                    timeout,
   output logic                    done,
   output logic [XLEN-1:0]         halt_pc,
   output logic                    pc_error
);

   localparam int LOOP_W = $clog2(HALT_REPEAT + 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HALTED,
      ST_TIMED_OUT
   } state_e;

   state_e               state_q, state_d;
   logic [ORDER_W-1:0]   order_q;
   logic [ORDER_W-1:0]   acc_cnt;
   logic [LOOP_W-1:0]    loop_q, loop_d;
   logic [TIMEOUT_W-1:0] idle_q, idle_d, idle_inc;
   logic [XLEN-1:0]      halt_pc_q, halt_pc_d;
   logic                 halt_q, timeout_q, done_q;
   logic                 halt_hit, timeout_hit;
`ifdef COMMIT_MONITOR_PC_CHECK_EN
   logic [XLEN-1:0]      exp_pc_q, exp_pc_d;
   logic                 exp_vld_q, exp_vld_d;
   logic                 pc_err_q, pc_err_d;
`endif

   // Walk channels in index order: accept, number, and track self-loops.
   always_comb begin
      // NOTE: every variable gets a default before any conditional update so
      // no path leaves it unassigned, which would otherwise infer a latch.
      commit_accept = '0;
      order_out     = '0;
      acc_cnt       = '0;
      halt_hit      = 1'b0;
      loop_d        = loop_q;
      halt_pc_d     = halt_pc_q;
`ifdef COMMIT_MONITOR_PC_CHECK_EN
      exp_pc_d      = exp_pc_q;
      exp_vld_d     = exp_vld_q;
      pc_err_d      = pc_err_q;
`endif
      for (int i = 0; i < NRET; i++) begin
         order_out[i*ORDER_W +: ORDER_W] = order_q + acc_cnt;
         // Once a channel halts, higher channels in the same cycle are dropped.
         if (state_q == ST_RUN && commit_valid[i] && !halt_hit) begin
            commit_accept[i] = 1'b1;
            acc_cnt          = acc_cnt + 1'b1;
            if (commit_is_ctrl[i] &&
                commit_next_pc[i*XLEN +: XLEN] == commit_pc[i*XLEN +: XLEN]) begin
               loop_d = loop_d + 1'b1;
               if (loop_d == LOOP_W'(HALT_REPEAT)) begin
                  halt_hit  = 1'b1;
                  halt_pc_d = commit_pc[i*XLEN +: XLEN];
               end
            end else begin
               loop_d = '0;
            end
`ifdef COMMIT_MONITOR_PC_CHECK_EN
            // Chained channels compare against the previous channel's next_pc.
            if (exp_vld_d && commit_pc[i*XLEN +: XLEN] != exp_pc_d) begin
               pc_err_d = 1'b1;
            end
            exp_pc_d  = commit_next_pc[i*XLEN +: XLEN];
            exp_vld_d = 1'b1;
`endif
         end
      end
   end

   // Idle counting, timeout detection and next-state selection.
   always_comb begin
      state_d     = state_q;
      idle_d      = idle_q;
      idle_inc    = idle_q + 1'b1;
      timeout_hit = 1'b0;
      if (state_q == ST_RUN) begin
         if (acc_cnt == '0) begin
            // Equality compare: lowering the limit below the count never fires.
            timeout_hit = (timeout_limit != '0) && (idle_inc == timeout_limit);
            if (idle_q != '1) begin
               idle_d = idle_inc;
            end
         end else begin
            idle_d = '0;
         end
         if (halt_hit) begin
            state_d = ST_HALTED;
         end else if (timeout_hit) begin
            state_d = ST_TIMED_OUT;
         end
      end
   end

   // State, counters and registered status flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         order_q   <= '0;
         loop_q    <= '0;
         idle_q    <= '0;
         halt_pc_q <= '0;
         halt_q    <= 1'b0;
         timeout_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge values regardless of statement order.
         state_q   <= state_d;
         order_q   <= order_q + acc_cnt;
         loop_q    <= loop_d;
         idle_q    <= idle_d;
         halt_pc_q <= halt_pc_d;
         halt_q    <= (state_d == ST_HALTED);
         timeout_q <= (state_d == ST_TIMED_OUT);
         done_q    <= (state_d != ST_RUN);
      end
   end

`ifdef COMMIT_MONITOR_PC_CHECK_EN
   // Expected-PC tracker and sticky discontinuity flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_pc_q  <= '0;
         exp_vld_q <= 1'b0;
         pc_err_q  <= 1'b0;
      end else begin
         exp_pc_q  <= exp_pc_d;
         exp_vld_q <= exp_vld_d;
         pc_err_q  <= pc_err_d;
      end
   end

   assign pc_error = pc_err_q;
`else
   assign pc_error = 1'b0;
`endif

   assign order_next = order_q;
   assign halt       = halt_q;
   assign timeout    = timeout_q;
   assign done       = done_q;
   assign halt_pc    = halt_pc_q;

endmodule

// File: tb/tb_commit_monitor.sv
// Self-checking bench for commit_monitor: directed scenarios plus a
// randomized run compared against a behavioural model of the retire rules.
module tb_commit_monitor;

   localparam int NRET        = 4;
   localparam int XLEN        = 32;
   localparam int ORDER_W     = 8;
   localparam int TIMEOUT_W   = 8;
   localparam int HALT_REPEAT = 2;

   logic                    clk;
   logic                    rst;
   logic [NRET-1:0]         commit_valid;
   logic [NRET*XLEN-1:0]    commit_pc;
   logic [NRET*XLEN-1:0]    commit_next_pc;
   logic [NRET-1:0]         commit_is_ctrl;
   logic [TIMEOUT_W-1:0]    timeout_limit;
   logic [NRET*ORDER_W-1:0] order_out;
   logic [NRET-1:0]         commit_accept;
   logic [ORDER_W-1:0]      order_next;
   logic                    halt, timeout, done, pc_error;
   logic [XLEN-1:0]         halt_pc;

   int n_checks = 0;
   int n_errors = 0;

   commit_monitor #(
      .NRET(NRET), .XLEN(XLEN), .ORDER_W(ORDER_W),
      .TIMEOUT_W(TIMEOUT_W), .HALT_REPEAT(HALT_REPEAT)
   ) dut (
      .clk(clk), .rst(rst),
      .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_next_pc(commit_next_pc), .commit_is_ctrl(commit_is_ctrl),
      .timeout_limit(timeout_limit), .order_out(order_out),
      .commit_accept(commit_accept), .order_next(order_next),
      .halt(halt), .timeout(timeout), .done(done),
      .halt_pc(halt_pc), .pc_error(pc_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: architectural state of the monitor as plain integers.
   typedef struct {
      int          order;
      int          loops;
      int          idle;
      bit          halted;
      bit          timed_out;
      logic [31:0] halt_pc;
      logic [31:0] exp_pc;
      bit          exp_vld;
      bit          pc_err;
   } model_t;

   model_t      m, p;
   bit [NRET-1:0] e_accept;
   int          e_order[NRET];
   logic [31:0] d_pc[NRET];
   logic [31:0] d_npc[NRET];

   task automatic model_reset();
      m = '{order: 0, loops: 0, idle: 0, halted: 0, timed_out: 0,
            halt_pc: 32'h0, exp_pc: 32'h0, exp_vld: 0, pc_err: 0};
      p = m;
   endtask

   // Apply inputs and predict this cycle's outputs plus the post-edge state.
   task automatic drive(input logic [NRET-1:0] v, input logic [NRET-1:0] c);
      int cnt;
      bit hit;
      cnt = 0;
      hit = 0;
      p = m;
      e_accept = '0;
      for (int i = 0; i < NRET; i++) begin
         commit_pc[i*XLEN +: XLEN]      = d_pc[i];
         commit_next_pc[i*XLEN +: XLEN] = d_npc[i];
         e_order[i] = (m.order + cnt) % 256;
         if (!m.halted && !m.timed_out && v[i] && !hit) begin
            e_accept[i] = 1'b1;
            cnt++;
            if (c[i] && d_npc[i] == d_pc[i]) begin
               p.loops++;
               if (p.loops == HALT_REPEAT) begin
                  hit = 1;
                  p.halted = 1;
                  p.halt_pc = d_pc[i];
               end
            end else begin
               p.loops = 0;
            end
`ifdef COMMIT_MONITOR_PC_CHECK_EN
            if (p.exp_vld && d_pc[i] != p.exp_pc) p.pc_err = 1;
            p.exp_pc  = d_npc[i];
            p.exp_vld = 1;
`endif
         end
      end
      p.order = (m.order + cnt) % 256;
      if (!m.halted && !m.timed_out) begin
         if (cnt == 0) begin
            if (timeout_limit != 0 && m.idle + 1 == int'(timeout_limit)) p.timed_out = 1;
            p.idle = (m.idle == 255) ? 255 : m.idle + 1;
         end else begin
            p.idle = 0;
         end
      end
      commit_valid   = v;
      commit_is_ctrl = c;
   endtask

   task automatic tick();
      @(posedge clk);
      m = p;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      commit_valid = '0;
      commit_is_ctrl = '0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic idle_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         drive('0, '0);
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      commit_valid = '0;
      commit_is_ctrl = '0;
      commit_pc = '0;
      commit_next_pc = '0;
      timeout_limit = '0;
      model_reset();
      #1;
      n_checks += 6;
      if (order_next !== 8'd0) begin n_errors++; $display("FAIL reset_order_next: got %0d expected 0", order_next); end
      if (halt !== 1'b0)       begin n_errors++; $display("FAIL reset_halt: got %b expected 0", halt); end
      if (timeout !== 1'b0)    begin n_errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
      if (done !== 1'b0)       begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
      if (halt_pc !== 32'h0)   begin n_errors++; $display("FAIL reset_halt_pc: got %0h expected 0", halt_pc); end
      if (pc_error !== 1'b0)   begin n_errors++; $display("FAIL reset_pc_error: got %b expected 0", pc_error); end
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_order();
      logic [31:0] pcs[3];
      pcs = '{32'h60, 32'h64, 32'h68};
      do_reset();
      for (int k = 0; k < 3; k++) begin
         d_pc[0] = pcs[k];
         d_npc[0] = pcs[k] + 4;
         drive(4'b0001, 4'b0000);
         #3;
         n_checks += 2;
         if (commit_accept !== 4'b0001) begin n_errors++; $display("FAIL seq_accept: got %b expected 0001", commit_accept); end
         if (order_out[0 +: 8] !== 8'(k)) begin n_errors++; $display("FAIL seq_order: got %0d expected %0d", order_out[0 +: 8], k); end
         tick();
      end
      n_checks += 2;
      if (order_next !== 8'd3) begin n_errors++; $display("FAIL seq_order_next: got %0d expected 3", order_next); end
      if (halt !== 1'b0) begin n_errors++; $display("FAIL seq_halt: got %b expected 0", halt); end
      // Sparse channels: numbering follows accepted channels only.
      for (int i = 0; i < NRET; i++) begin
         d_pc[i] = 32'h6c + 32'(4 * i);
         d_npc[i] = d_pc[i] + 4;
      end
      drive(4'b1010, 4'b0000);
      #3;
      n_checks += 3;
      if (commit_accept !== 4'b1010) begin n_errors++; $display("FAIL sparse_accept: got %b expected 1010", commit_accept); end
      if (order_out[8 +: 8] !== 8'd3) begin n_errors++; $display("FAIL sparse_order1: got %0d expected 3", order_out[8 +: 8]); end
      if (order_out[24 +: 8] !== 8'd4) begin n_errors++; $display("FAIL sparse_order3: got %0d expected 4", order_out[24 +: 8]); end
      tick();
      n_checks++;
      if (order_next !== 8'd5) begin n_errors++; $display("FAIL sparse_order_next: got %0d expected 5", order_next); end
   endtask

   task automatic test_halt();
      do_reset();
      // Loop count must reset on an intervening non-loop commit.
      d_pc[0] = 32'h200; d_npc[0] = 32'h200; drive(4'b0001, 4'b0001); tick();
      d_pc[0] = 32'h200; d_npc[0] = 32'h204; drive(4'b0001, 4'b0001); tick();
      d_pc[0] = 32'h204; d_npc[0] = 32'h204; drive(4'b0001, 4'b0001); tick();
      n_checks++;
      if (halt !== 1'b0) begin n_errors++; $display("FAIL loop_reset_halt: got %b expected 0", halt); end
      do_reset();
      for (int i = 0; i < NRET; i++) begin
         d_pc[i]  = 32'h100;
         d_npc[i] = (i < 2) ? 32'h100 : 32'h104;
      end
      drive(4'b1111, 4'b0011);
      #3;
      n_checks += 3;
      if (commit_accept !== 4'b0011) begin n_errors++; $display("FAIL halt_accept: got %b expected 0011", commit_accept); end
      if (order_out[0 +: 8] !== 8'd0) begin n_errors++; $display("FAIL halt_order0: got %0d expected 0", order_out[0 +: 8]); end
      if (order_out[8 +: 8] !== 8'd1) begin n_errors++; $display("FAIL halt_order1: got %0d expected 1", order_out[8 +: 8]); end
      tick();
      n_checks += 4;
      if (halt !== 1'b1) begin n_errors++; $display("FAIL halt_flag: got %b expected 1", halt); end
      if (done !== 1'b1) begin n_errors++; $display("FAIL halt_done: got %b expected 1", done); end
      if (halt_pc !== 32'h100) begin n_errors++; $display("FAIL halt_pc: got %0h expected 100", halt_pc); end
      if (order_next !== 8'd2) begin n_errors++; $display("FAIL halt_order_next: got %0d expected 2", order_next); end
      drive(4'b1111, 4'b0000);
      #3;
      n_checks++;
      if (commit_accept !== 4'b0000) begin n_errors++; $display("FAIL halted_accept: got %b expected 0000", commit_accept); end
      tick();
      n_checks++;
      if (order_next !== 8'd2) begin n_errors++; $display("FAIL halted_order_frozen: got %0d expected 2", order_next); end
      // Asynchronous reset while halted, checked before any clock edge.
      #2;
      rst = 1'b0;
      #1;
      n_checks += 4;
      if (halt !== 1'b0) begin n_errors++; $display("FAIL async_halt: got %b expected 0", halt); end
      if (done !== 1'b0) begin n_errors++; $display("FAIL async_done: got %b expected 0", done); end
      if (halt_pc !== 32'h0) begin n_errors++; $display("FAIL async_halt_pc: got %0h expected 0", halt_pc); end
      if (order_next !== 8'd0) begin n_errors++; $display("FAIL async_order_next: got %0d expected 0", order_next); end
      commit_valid = '0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic test_timeout();
      do_reset();
      timeout_limit = 8'd5;
      for (int k = 1; k <= 5; k++) begin
         drive('0, '0);
         tick();
         n_checks++;
         if (timeout !== (k == 5)) begin n_errors++; $display("FAIL timeout_cycle%0d: got %b expected %b", k, timeout, k == 5); end
      end
      n_checks++;
      if (done !== 1'b1) begin n_errors++; $display("FAIL timeout_done: got %b expected 1", done); end
      // A commit at idle=3 restarts the count.
      do_reset();
      timeout_limit = 8'd5;
      idle_ticks(3);
      d_pc[0] = 32'h40; d_npc[0] = 32'h44;
      drive(4'b0001, 4'b0000);
      tick();
      for (int k = 1; k <= 5; k++) begin
         drive('0, '0);
         tick();
         n_checks++;
         if (timeout !== (k == 5)) begin n_errors++; $display("FAIL timeout_restart%0d: got %b expected %b", k, timeout, k == 5); end
      end
      // Limit 0 disables; lowering below the count never fires.
      do_reset();
      timeout_limit = 8'd0;
      idle_ticks(20);
      n_checks++;
      if (timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_disabled: got %b expected 0", timeout); end
      timeout_limit = 8'd2;
      idle_ticks(10);
      n_checks++;
      if (timeout !== 1'b0) begin n_errors++; $display("FAIL timeout_lowered: got %b expected 0", timeout); end
      timeout_limit = 8'd0;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int k = 0; k < 70; k++) begin
         for (int i = 0; i < NRET; i++) begin
            d_pc[i] = 32'h1000 + 32'(16 * k + 4 * i);
            d_npc[i] = d_pc[i] + 4;
         end
         drive(4'b1111, 4'b0000);
         tick();
      end
      n_checks++;
      if (order_next !== 8'd24) begin n_errors++; $display("FAIL wrap_order_next: got %0d expected 24", order_next); end
   endtask

   task automatic test_pc_check();
      bit exp_err;
`ifdef COMMIT_MONITOR_PC_CHECK_EN
      exp_err = 1;
`else
      exp_err = 0;
`endif
      do_reset();
      d_pc[0] = 32'h10; d_npc[0] = 32'h14; drive(4'b0001, 4'b0000); tick();
      n_checks++;
      if (pc_error !== 1'b0) begin n_errors++; $display("FAIL pc_first: got %b expected 0", pc_error); end
      d_pc[0] = 32'h20; d_npc[0] = 32'h24; drive(4'b0001, 4'b0000); tick();
      n_checks++;
      if (pc_error !== exp_err) begin n_errors++; $display("FAIL pc_jump: got %b expected %b", pc_error, exp_err); end
      // Discontinuity between chained channels within one cycle.
      do_reset();
      d_pc[0] = 32'h10; d_npc[0] = 32'h14;
      d_pc[1] = 32'h18; d_npc[1] = 32'h1c;
      drive(4'b0011, 4'b0000);
      tick();
      n_checks++;
      if (pc_error !== exp_err) begin n_errors++; $display("FAIL pc_chained: got %b expected %b", pc_error, exp_err); end
   endtask

   task automatic test_random();
      logic [31:0] r_pc;
      do_reset();
      timeout_limit = '0;
      r_pc = 32'h1000;
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic [NRET-1:0] v, c;
         int sel;
         if (m.halted || m.timed_out) begin
            do_reset();
            timeout_limit = ($urandom_range(0, 3) == 0) ? TIMEOUT_W'($urandom_range(1, 6)) : '0;
         end
         v = ($urandom_range(0, 3) == 0) ? '0 : NRET'($urandom);
         c = '0;
         for (int i = 0; i < NRET; i++) begin
            sel = $urandom_range(0, 15);
            d_pc[i] = r_pc;
            if (sel == 0) begin
               c[i] = 1'b1; d_npc[i] = r_pc;
            end else if (sel < 3) begin
               c[i] = 1'b1; d_npc[i] = r_pc + 32'h40;
            end else if (sel == 3) begin
               d_pc[i] = $urandom & 32'hffff_fffc; d_npc[i] = d_pc[i] + 4;
            end else begin
               d_npc[i] = r_pc + 4;
            end
            if (v[i]) r_pc = d_npc[i];
         end
         drive(v, c);
         #3;
         n_checks++;
         if (commit_accept !== e_accept) begin n_errors++; $display("FAIL rnd_accept cyc%0d: got %b expected %b", cyc, commit_accept, e_accept); end
         for (int i = 0; i < NRET; i++) begin
            if (e_accept[i]) begin
               n_checks++;
               if (order_out[i*ORDER_W +: ORDER_W] !== ORDER_W'(e_order[i])) begin
                  n_errors++;
                  $display("FAIL rnd_order cyc%0d ch%0d: got %0d expected %0d", cyc, i, order_out[i*ORDER_W +: ORDER_W], e_order[i]);
               end
            end
         end
         tick();
         n_checks += 5;
         if (order_next !== ORDER_W'(m.order)) begin n_errors++; $display("FAIL rnd_order_next cyc%0d: got %0d expected %0d", cyc, order_next, m.order); end
         if (halt !== m.halted) begin n_errors++; $display("FAIL rnd_halt cyc%0d: got %b expected %b", cyc, halt, m.halted); end
         if (timeout !== m.timed_out) begin n_errors++; $display("FAIL rnd_timeout cyc%0d: got %b expected %b", cyc, timeout, m.timed_out); end
         if (done !== (m.halted | m.timed_out)) begin n_errors++; $display("FAIL rnd_done cyc%0d: got %b expected %b", cyc, done, m.halted | m.timed_out); end
         if (pc_error !== m.pc_err) begin n_errors++; $display("FAIL rnd_pc_error cyc%0d: got %b expected %b", cyc, pc_error, m.pc_err); end
         if (m.halted) begin
            n_checks++;
            if (halt_pc !== m.halt_pc) begin n_errors++; $display("FAIL rnd_halt_pc cyc%0d: got %0h expected %0h", cyc, halt_pc, m.halt_pc); end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < NRET; i++) begin
         d_pc[i] = '0;
         d_npc[i] = '0;
      end
      test_reset();
      test_order();
      test_halt();
      test_timeout();
      test_wrap();
      test_pc_check();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
